// File: rtl/led_scan_controller.sv
// led_scan_controller: four-digit time-multiplexed scanner with frame-synchronous double-buffered display value.
module led_scan_controller #(
    parameter int DIV_WIDTH    = 16,
    parameter int BLANK_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        blank_all,
    output logic [3:0]  char,
    output logic [3:0]  an,
    output logic        frame_start,
    output logic        pending
);
    localparam logic [DIV_WIDTH-1:0] BLANK_LIM = DIV_WIDTH'(BLANK_CYCLES);

    logic [DIV_WIDTH-1:0] cnt;
    logic [1:0]           idx;
    logic [15:0]          disp;
    logic [15:0]          pend;
    logic [15:0]          disp_next;
    logic                 boundary;
    logic                 in_blank;

    // cnt/idx name the slot position the outputs are about to present, so the
    // edge ending the digit-0 slot sees cnt==0, idx==3
    assign boundary  = (cnt == '0) && (idx == 2'd3);
    assign disp_next = (boundary && pending) ? pend : disp;

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = cnt < BLANK_LIM;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= 2'd3;
            disp        <= 16'h0000;
            pend        <= 16'h0000;
            pending     <= 1'b0;
            char        <= 4'h0;
            an          <= 4'b1111;
            frame_start <= 1'b0;
        end else begin
            cnt         <= cnt + 1'b1;
            if (&cnt)
                idx     <= idx - 2'd1;
            disp        <= disp_next;
            if (load)
                pend    <= data_in;
            pending     <= load | (pending & ~boundary);
            char        <= disp_next[{idx, 2'b00} +: 4];
            an          <= (in_blank || blank_all) ? 4'b1111 : ~(4'b0001 << idx);
            frame_start <= boundary;
        end
    end
endmodule

// File: tb/tb_led_scan_controller.sv
// tb_led_scan_controller: directed checks of scan order, blanking, double buffering and reset.
module tb_led_scan_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic        load = 1'b0;
    logic        blank_all = 1'b0;
    logic [3:0]  char;
    logic [3:0]  an;
    logic        frame_start;
    logic        pending;
    int          checks = 0;
    int          failures = 0;
    int          k = -1;

    led_scan_controller #(.DIV_WIDTH(3), .BLANK_CYCLES(2)) dut (
        .clk(clk),
        .reset(reset),
        .data_in(data_in),
        .load(load),
        .blank_all(blank_all),
        .char(char),
        .an(an),
        .frame_start(frame_start),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // expected anodes at clock c of a frame: 2 blank clocks then the slot's digit
    function automatic logic [3:0] slot_an(input int c);
        int d;
        d = 3 - (c / 8) % 4;
        return (c % 8 < 2) ? 4'b1111 : ~(4'b0001 << d);
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input int c);
        int d;
        d = 3 - (c / 8) % 4;
        return v[d*4 +: 4];
    endfunction

    // active-low abcdefg decoder, MSB = segment a
    function automatic logic [6:0] seg(input logic [3:0] c);
        case (c)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'hA: return 7'b0001000;
            4'hF: return 7'b0111000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s clock=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        load = 1'b0;
        blank_all = 1'b0;
        #1;
        @(posedge clk);
        #1;
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_char", 16'(char), 16'h0);
        chk("rst_fs", 16'(frame_start), 16'h0);
        chk("rst_pend", 16'(pending), 16'h0);
        reset = 1'b0;
        k = -1;
    endtask

    initial begin
        // idle scan, no load
        do_reset();
        for (int i = 0; i <= 64; i++) begin
            tick();
            chk("idle_fs", 16'(frame_start), 16'((k % 32) == 0));
            chk("idle_an", 16'(an), 16'(slot_an(k)));
            chk("idle_char", 16'(char), 16'h0);
        end

        // load 1A2F on clock 3, blank_all sampled for clocks 40..60
        do_reset();
        for (int i = 0; i <= 64; i++) begin
            tick();
            load = (k == 3);
            data_in = 16'h1A2F;
            blank_all = (k >= 39 && k <= 59);
            chk("b_pend", 16'(pending), 16'(k >= 4 && k <= 31));
            chk("b_char", 16'(char), 16'(k < 32 ? 4'h0 : nib(16'h1A2F, k)));
            chk("b_an", 16'(an), 16'((k >= 40 && k <= 60) ? 4'hF : slot_an(k)));
            chk("b_fs", 16'(frame_start), 16'((k % 32) == 0));
            if (k == 32) chk("led_d3", 16'(seg(char)), 16'(7'b1001111));
            if (k == 40) chk("led_d2", 16'(seg(char)), 16'(7'b0001000));
            if (k == 48) chk("led_d1", 16'(seg(char)), 16'(7'b0010010));
            if (k == 56) chk("led_d0", 16'(seg(char)), 16'(7'b0111000));
        end
        load = 1'b0;
        blank_all = 1'b0;

        // last write wins: 1111 then 2222
        do_reset();
        for (int i = 0; i <= 40; i++) begin
            tick();
            load = (k == 5 || k == 20);
            data_in = (k == 5) ? 16'h1111 : 16'h2222;
            chk("c_pend", 16'(pending), 16'(k >= 6 && k <= 31));
            chk("c_char", 16'(char), 16'(k < 32 ? 4'h0 : 4'h2));
        end
        load = 1'b0;

        // load on the boundary clock with 4444 already pending
        do_reset();
        for (int i = 0; i <= 72; i++) begin
            tick();
            load = (k == 10 || k == 31);
            data_in = (k == 10) ? 16'h4444 : 16'h3333;
            chk("d_pend", 16'(pending), 16'(k >= 11 && k <= 63));
            chk("d_char", 16'(char), 16'(k < 32 ? 4'h0 : (k < 64 ? 4'h4 : 4'h3)));
        end
        load = 1'b0;

        // asynchronous reset mid-slot with 5555 pending
        do_reset();
        for (int i = 0; i <= 45; i++) begin
            tick();
            load = (k == 3 || k == 40);
            data_in = (k == 3) ? 16'h1A2F : 16'h5555;
        end
        load = 1'b0;
        chk("e_char45", 16'(char), 16'hA);
        chk("e_an45", 16'(an), 16'hB);
        chk("e_pend45", 16'(pending), 16'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("e_async_an", 16'(an), 16'hF);
        chk("e_async_char", 16'(char), 16'h0);
        chk("e_async_fs", 16'(frame_start), 16'h0);
        chk("e_async_pend", 16'(pending), 16'h0);
        do_reset();
        for (int i = 0; i <= 40; i++) begin
            tick();
            chk("e_fs", 16'(frame_start), 16'((k % 32) == 0));
            chk("e_an", 16'(an), 16'(slot_an(k)));
            chk("e_char", 16'(char), 16'h0);
            chk("e_pend", 16'(pending), 16'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
